// File: rtl/mem_dump_pkg.sv
// Shared state encoding and byte/word constants for the memory dump readback path.
package mem_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    DONE
  } dump_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;

endpackage

// File: rtl/dump_byte_shifter.sv
// Holds one memory read result and hands it out LSB-first, one byte per shift.
// Load takes effect next cycle; shift only advances while beats remain, so a stalled consumer simply holds the byte.
module dump_byte_shifter
  import mem_dump_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_load,
  input  logic              i_word,
  input  logic [31:0]       i_rdata,
  input  logic              i_shift,
  output logic [BYTE_W-1:0] o_byte_out,
  output logic              o_last
);

  logic [31:0] r_buf;
  logic [2:0]  r_nb;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_buf <= '0;
      r_nb  <= '0;
    end else if (i_load) begin
      // Byte reads only carry data in [7:0]; the upper bits are never emitted.
      r_buf <= i_rdata;
      r_nb  <= i_word ? 3'(BYTES_PER_WORD) : 3'd1;
    end else if (i_shift && (r_nb != 3'd0)) begin
      r_buf <= r_buf >> BYTE_W;
      r_nb  <= r_nb - 3'd1;
    end
  end

  assign o_byte_out = r_buf[BYTE_W-1:0];
  assign o_last     = (r_nb == 3'd1);

endmodule

// File: rtl/mem_dump_reader.sv
// Streams a memory region out little-endian over a byte valid/ready port, word reads where aligned.
// First read one cycle after start, first byte three cycles after; tx_ready low freezes the current byte.
module mem_dump_reader
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 7
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_words,
  input  logic [31:0]       i_mem_rdata,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready
);

  dump_state_t r_state;
  dump_state_t w_next;

  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_ci;
  logic              r_word;

  logic [ADDR_W-1:0] w_addr;
  logic [LEN_W-1:0]  w_remaining;
  logic              w_word_ok;
  logic              w_accept;
  logic              w_last;
  logic [7:0]        w_byte;

  assign w_addr      = r_base + ADDR_W'(r_ci);
  assign w_remaining = r_len - r_ci;
  assign w_word_ok   = (w_remaining >= LEN_W'(BYTES_PER_WORD)) && (w_addr[1:0] == 2'b00);
  assign w_accept    = (r_state == SEND) && i_tx_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next = (i_len == '0) ? DONE : READ;
        end
      end
      READ: w_next = WAIT;
      WAIT: w_next = SEND;
      SEND: begin
        if (w_accept && w_last) begin
          w_next = ((r_ci + LEN_W'(1)) == r_len) ? DONE : READ;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_len   <= '0;
      r_ci    <= '0;
      r_word  <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && i_start) begin
        r_base <= i_base_addr;
        r_len  <= i_len;
        r_ci   <= '0;
      end
      // Access width is decided at issue time and must stay fixed until the data lands.
      if (r_state == READ) begin
        r_word <= w_word_ok;
      end
      if (w_accept) begin
        r_ci <= r_ci + LEN_W'(1);
      end
    end
  end

  dump_byte_shifter u_shifter (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_load     (r_state == WAIT),
    .i_word     (r_word),
    .i_rdata    (i_mem_rdata),
    .i_shift    (w_accept),
    .o_byte_out (w_byte),
    .o_last     (w_last)
  );

  assign o_busy      = (r_state == READ) || (r_state == WAIT) || (r_state == SEND);
  assign o_done      = (r_state == DONE);
  assign o_mem_rd_en = (r_state == READ);
  assign o_mem_addr  = w_addr;
  assign o_mem_words = (r_state == READ) && w_word_ok;
  assign o_tx_valid  = (r_state == SEND);
  assign o_tx_data   = w_byte;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed and randomized dump transfers checked against a byte-level memory model.
module tb_mem_dump_reader;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 7;

  logic              clk = 1'b0;
  logic              i_rstn;
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic [LEN_W-1:0]  i_len;
  logic              o_busy;
  logic              o_done;
  logic              o_mem_rd_en;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_words;
  logic [31:0]       i_mem_rdata;
  logic [7:0]        o_tx_data;
  logic              o_tx_valid;
  logic              i_tx_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:1023];

  always #5 clk = ~clk;

  mem_dump_reader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .i_clk       (clk),
    .i_rstn      (i_rstn),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_len       (i_len),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_mem_rd_en (o_mem_rd_en),
    .o_mem_addr  (o_mem_addr),
    .o_mem_words (o_mem_words),
    .i_mem_rdata (i_mem_rdata),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mb(input logic [31:0] a);
    return mem[a[9:0]];
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},   32'(o_busy), 32'd0);
    check({tag, "_done"},   32'(o_done), 32'd0);
    check({tag, "_rd_en"},  32'(o_mem_rd_en), 32'd0);
    check({tag, "_words"},  32'(o_mem_words), 32'd0);
    check({tag, "_addr"},   o_mem_addr, 32'd0);
    check({tag, "_valid"},  32'(o_tx_valid), 32'd0);
    check({tag, "_data"},   32'(o_tx_data), 32'd0);
  endtask

  // One transfer: expected accesses/bytes/timing come from the plain byte-walk rules.
  task automatic run_xfer(input logic [31:0] base, input int len, input bit rnd,
                          input int abort_at, input string tag);
    logic [31:0] exp_addr[$];
    bit          exp_word[$];
    logic [31:0] got_addr[$];
    bit          got_word[$];
    logic [7:0]  got_b[$];
    logic [31:0] a;
    logic [31:0] r;
    logic [7:0]  prev_data;
    bit          prev_stall;
    bit          finished;
    int          off, exp_done_cyc, cyc, done_cnt, done_cyc, first_rd, first_tx;

    off = 0;
    exp_done_cyc = 1;
    while (off < len) begin
      a = base + 32'(off);
      exp_addr.push_back(a);
      if ((len - off >= 4) && (a[1:0] == 2'b00)) begin
        exp_word.push_back(1'b1);
        off += 4;
        exp_done_cyc += 6;
      end else begin
        exp_word.push_back(1'b0);
        off += 1;
        exp_done_cyc += 3;
      end
    end

    @(negedge clk);
    i_base_addr = base;
    i_len       = LEN_W'(len);
    i_start     = 1'b1;
    i_tx_ready  = 1'b1;
    cyc = 0; done_cnt = 0; done_cyc = -1; first_rd = -1; first_tx = -1;
    prev_stall = 1'b0; prev_data = 8'h00; finished = 1'b0;

    while (!finished && cyc < 3000) begin
      @(negedge clk);
      i_start = 1'b0;
      cyc++;
      if (abort_at > 0 && cyc == abort_at) begin
        i_rstn = 1'b0;
        @(negedge clk);
        check_quiet({tag, "_after_abort"});
        check({tag, "_abort_no_done"}, 32'(done_cnt), 32'd0);
        i_rstn = 1'b1;
        i_tx_ready = 1'b1;
        return;
      end
      if (o_mem_rd_en) begin
        got_addr.push_back(o_mem_addr);
        got_word.push_back(o_mem_words);
        if (first_rd < 0) first_rd = cyc;
        a = o_mem_addr;
        if (o_mem_words) begin
          i_mem_rdata = {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
        end else begin
          r = $urandom;
          i_mem_rdata = {r[31:8], mb(a)};
        end
      end
      if (o_tx_valid && first_tx < 0) first_tx = cyc;
      if (prev_stall) begin
        check({tag, "_stall_valid"}, 32'(o_tx_valid), 32'd1);
        check({tag, "_stall_data"}, 32'(o_tx_data), 32'(prev_data));
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        check({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
        finished = 1'b1;
        // A start during DONE must not launch a new transfer.
        i_start = 1'b1;
        i_base_addr = $urandom;
        i_len = LEN_W'(5);
      end
      i_tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = o_tx_valid && !i_tx_ready;
      prev_data  = o_tx_data;
      if (o_tx_valid && i_tx_ready) got_b.push_back(o_tx_data);
    end

    check({tag, "_finished"}, 32'(finished), 32'd1);
    @(negedge clk);
    i_start = 1'b0;
    check({tag, "_done_once"}, 32'(o_done), 32'd0);
    check({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_start_in_done_ignored"}, 32'(o_mem_rd_en), 32'd0);

    check({tag, "_n_access"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check($sformatf("%s_acc%0d_addr", tag, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s_acc%0d_word", tag, i), 32'(got_word[i]), 32'(exp_word[i]));
    end
    check({tag, "_n_bytes"}, 32'(got_b.size()), 32'(len));
    for (int i = 0; i < len && i < got_b.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(got_b[i]), 32'(mb(base + 32'(i))));
    end
    if (!rnd) check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
    if (len > 0) begin
      check({tag, "_first_rd_cycle"}, 32'(first_rd), 32'd1);
      check({tag, "_first_tx_cycle"}, 32'(first_tx), 32'd3);
    end else begin
      check({tag, "_no_rd"}, 32'(first_rd), 32'hFFFF_FFFF);
      check({tag, "_no_tx"}, 32'(first_tx), 32'hFFFF_FFFF);
    end
  endtask

  initial begin
    i_rstn      = 1'b0;
    i_start     = 1'b0;
    i_base_addr = '0;
    i_len       = '0;
    i_mem_rdata = '0;
    i_tx_ready  = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) mem[10'h100 + i] = 8'(8'h11 * (i + 1));

    repeat (3) @(negedge clk);
    check_quiet("reset");
    i_rstn = 1'b1;
    @(negedge clk);

    run_xfer(32'h100, 8, 1'b0, 0, "word8");
    run_xfer(32'h100, 6, 1'b0, 0, "len6");
    run_xfer(32'h102, 7, 1'b0, 0, "unaligned7");
    run_xfer(32'h100, 0, 1'b0, 0, "len0");
    run_xfer(32'h100, 8, 1'b1, 0, "stall8");
    run_xfer(32'h200, 8, 1'b0, 4, "abort");
    run_xfer(32'h300, 4, 1'b0, 0, "after_abort");
    run_xfer(32'hFFFF_FFFE, 6, 1'b0, 0, "wrap");
    run_xfer($urandom, 127, 1'b1, 0, "maxlen");
    for (int k = 0; k < 6; k++) begin
      run_xfer($urandom, int'($urandom_range(0, 20)), 1'b1, 0, $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
